// File: rtl/nios2_sysid_regs.sv
// nios2_sysid_regs
//   System-ID register block. It is an Avalon-MM slave on the Nios II data
//   bus, and software reads it to identify the hardware build.
//
//   Word map:
//     0 SYSTEM_ID (RO)
//     1 TIMESTAMP (RO)
//     2 UPTIME_LO (RO, live; reading also snapshots UPTIME_HI)
//     3 UPTIME_HI (RO snapshot)
//     4 SCRATCH   (RW, byte-enabled)
//     5 FEATURES  (RO)
//     6,7         read 0, writes ignored
//
//   Ports:
//     clock          system clock
//     reset_n        synchronous reset, active low
//     address[2:0]   word address
//     read, write    bus strobes (no waitrequest; every read is accepted)
//     writedata[31:0], byteenable[3:0]   write data and byte lanes
//     readdata[31:0] read data; holds its last value while readdatavalid=0
//     readdatavalid  one-cycle pulse, READ_LATENCY cycles after each accepted read
//     heartbeat      toggles every HB_DIV clocks (only with SYSID_HEARTBEAT_EN)
//
//   Optional feature macro: SYSID_HEARTBEAT_EN
//     Adds the heartbeat port and its divider, and forces FEATURES[31] to 1.
module nios2_sysid_regs #(
  parameter logic [31:0] SYSTEM_ID    = 32'hCAFE_0001,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter logic [31:0] FEATURES     = 32'd0,
  parameter logic [31:0] SCRATCH_INIT = 32'd0,
  parameter int          READ_LATENCY = 1,
  parameter int unsigned HB_DIV       = 50_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
`ifdef SYSID_HEARTBEAT_EN
  ,
  output logic        heartbeat
`endif
);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("nios2_sysid_regs: READ_LATENCY must be in 1..4");
    end
  endgenerate

`ifdef SYSID_HEARTBEAT_EN
  localparam logic [31:0] FEATURES_EFF = FEATURES | 32'h8000_0000;
`else
  localparam logic [31:0] FEATURES_EFF = FEATURES;
`endif

  logic [63:0] uptime;
  logic [31:0] snapshot;
  logic [31:0] scratch;
  logic [31:0] rd_mux;
  logic        last_vld;
  logic [31:0] last_data;

  // Read mux: decodes the register values as they stand before this cycle's edge.
  // A write in the same cycle therefore commits after the read has sampled.
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = SYSTEM_ID;
      3'd1:    rd_mux = TIMESTAMP;
      3'd2:    rd_mux = uptime[31:0];
      3'd3:    rd_mux = snapshot;
      3'd4:    rd_mux = scratch;
      3'd5:    rd_mux = FEATURES_EFF;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) uptime <= '0;
    else          uptime <= uptime + 64'd1;
  end

  // The high word is captured in the same cycle as the low-word read.
  // A LO-then-HI read pair therefore sees one consistent 64-bit value.
  always_ff @(posedge clock) begin
    if (!reset_n)                       snapshot <= '0;
    else if (read && address == 3'd2)   snapshot <= uptime[63:32];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scratch <= SCRATCH_INIT;
    end else if (write && address == 3'd4) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) scratch[8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  // Stage p0 .. p(L-2): intermediate read pipeline. The output register below
  // is the final stage, so total latency is exactly READ_LATENCY.
  generate
    if (READ_LATENCY <= 1) begin : g_lat1
      assign last_vld  = read;
      assign last_data = rd_mux;
    end else begin : g_latn
      logic [31:0]             data_p [READ_LATENCY-1];
      logic [READ_LATENCY-2:0] vld_p;

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= read;
          for (int i = 1; i < READ_LATENCY-1; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clock) begin
        data_p[0] <= rd_mux;
        for (int i = 1; i < READ_LATENCY-1; i++) data_p[i] <= data_p[i-1];
      end

      assign last_vld  = vld_p[READ_LATENCY-2];
      assign last_data = data_p[READ_LATENCY-2];
    end
  endgenerate

  // Output stage: readdata only loads on a valid beat so it holds between pulses.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdatavalid <= 1'b0;
      readdata      <= '0;
    end else begin
      readdatavalid <= last_vld;
      if (last_vld) readdata <= last_data;
    end
  end

`ifdef SYSID_HEARTBEAT_EN
  logic [31:0] hb_div;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hb_div    <= '0;
      heartbeat <= 1'b0;
    end else if (hb_div == 32'(HB_DIV - 1)) begin
      hb_div    <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      hb_div    <= hb_div + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nios2_sysid_regs.sv
// Testbench for nios2_sysid_regs. It drives three instances (READ_LATENCY = 1, 2, 3)
// from a shared bus. Reads push the expected data and arrival cycle into a queue
// for each instance. A negedge monitor pops and compares whenever readdatavalid is high,
// and between pulses it checks that readdata holds its last value.
module tb_nios2_sysid_regs;

  localparam logic [31:0] SYSID    = 32'hCAFE_0001;
  localparam logic [31:0] TS       = 32'h0000_0000;
  localparam logic [31:0] FEAT     = 32'h0000_5A5A;
  localparam logic [31:0] SCR_INIT = 32'h0000_0000;
  localparam int          HBD      = 4;
`ifdef SYSID_HEARTBEAT_EN
  localparam logic [31:0] EXP_FEAT = 32'h8000_5A5A;
`else
  localparam logic [31:0] EXP_FEAT = 32'h0000_5A5A;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] rd0, rd1, rd2;
  logic        rv0, rv1, rv2;
`ifdef SYSID_HEARTBEAT_EN
  logic        hb0, hb1, hb2;
`endif

  logic [31:0] rd [3];
  logic        rv [3];
  assign rd[0] = rd0; assign rd[1] = rd1; assign rd[2] = rd2;
  assign rv[0] = rv0; assign rv[1] = rv1; assign rv[2] = rv2;

  always #5 clock = ~clock;

  nios2_sysid_regs #(.SYSTEM_ID(SYSID), .TIMESTAMP(TS), .FEATURES(FEAT),
    .SCRATCH_INIT(SCR_INIT), .READ_LATENCY(1), .HB_DIV(HBD)) u_l1 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rd0), .readdatavalid(rv0)
`ifdef SYSID_HEARTBEAT_EN
    , .heartbeat(hb0)
`endif
  );

  nios2_sysid_regs #(.SYSTEM_ID(SYSID), .TIMESTAMP(TS), .FEATURES(FEAT),
    .SCRATCH_INIT(SCR_INIT), .READ_LATENCY(2), .HB_DIV(HBD)) u_l2 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rd1), .readdatavalid(rv1)
`ifdef SYSID_HEARTBEAT_EN
    , .heartbeat(hb1)
`endif
  );

  nios2_sysid_regs #(.SYSTEM_ID(SYSID), .TIMESTAMP(TS), .FEATURES(FEAT),
    .SCRATCH_INIT(SCR_INIT), .READ_LATENCY(3), .HB_DIV(HBD)) u_l3 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rd2), .readdatavalid(rv2)
`ifdef SYSID_HEARTBEAT_EN
    , .heartbeat(hb2)
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          due;
    logic [2:0]  addr;
  } exp_t;

  exp_t        sb [3][$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        rst_seen = 1'b1;
  logic [31:0] last_rd [3];

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= !reset_n;
  end

  // Monitor: instance k has READ_LATENCY k+1.
  always @(negedge clock) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst_seen) begin
        sb[k].delete();
        last_rd[k] = '0;
        vectors++;
        if (rv[k] !== 1'b0 || rd[k] !== 32'h0) begin
          miscompares++;
          $display("FAIL reset_out lat%0d: valid=%b data=%h, required valid=0 data=00000000",
                   k+1, rv[k], rd[k]);
        end
      end else if (rv[k] === 1'b1) begin
        vectors++;
        if (sb[k].size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid lat%0d: data=%h at cycle %0d, required no pulse",
                   k+1, rd[k], cyc);
        end else begin
          e = sb[k].pop_front();
          if (rd[k] !== e.data || cyc != e.due) begin
            miscompares++;
            $display("FAIL read_addr%0d lat%0d: data=%h cycle=%0d, required data=%h cycle=%0d",
                     e.addr, k+1, rd[k], cyc, e.data, e.due);
          end
        end
        last_rd[k] = rd[k];
      end else begin
        if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
          e = sb[k].pop_front();
          vectors++;
          miscompares++;
          $display("FAIL missing_valid addr%0d lat%0d: no pulse by cycle %0d, required at %0d data=%h",
                   e.addr, k+1, cyc, e.due, e.data);
        end
        vectors++;
        if (rd[k] !== last_rd[k]) begin
          miscompares++;
          $display("FAIL hold lat%0d: readdata=%h while invalid, required %h",
                   k+1, rd[k], last_rd[k]);
        end
      end
    end
  end

  // Called at a negedge. It drives one bus cycle, and for a read it queues the
  // expected beat on every instance. It returns at the next negedge.
  task automatic bus(input logic r, input logic w, input logic [2:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic [31:0] exp_rd);
    exp_t e;
    read = r; write = w; address = a; writedata = wd; byteenable = be;
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        e.data = exp_rd; e.due = cyc + k + 1; e.addr = a;
        sb[k].push_back(e);
      end
    end
    @(negedge clock);
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   budget;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0;
    writedata = '0; byteenable = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

`ifdef SYSID_HEARTBEAT_EN
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      vectors++;
      if (hb0 !== 1'((k / HBD) % 2) || hb2 !== hb0) begin
        miscompares++;
        $display("FAIL heartbeat edge%0d: hb=%b, required %b", k, hb0, 1'((k / HBD) % 2));
      end
    end
`else
    @(negedge clock);
`endif

    // Back-to-back reads of the constant words.
    bus(1, 0, 3'd0, 32'h0, 4'h0, SYSID);
    bus(1, 0, 3'd1, 32'h0, 4'h0, TS);
    bus(1, 0, 3'd5, 32'h0, 4'h0, EXP_FEAT);
    bus(1, 0, 3'd6, 32'h0, 4'h0, 32'h0);
    bus(1, 0, 3'd7, 32'h0, 4'h0, 32'h0);
    repeat (4) @(negedge clock);

    // Scratch writes with byte lanes.
    bus(1, 0, 3'd4, 32'h0,         4'h0,    SCR_INIT);
    bus(0, 1, 3'd4, 32'h1122_3344, 4'b0101, 32'h0);
    bus(1, 0, 3'd4, 32'h0,         4'h0,    32'h0022_0044);
    bus(1, 1, 3'd4, 32'hAABB_CCDD, 4'b1111, 32'h0022_0044);
    bus(1, 0, 3'd4, 32'h0,         4'h0,    32'hAABB_CCDD);
    bus(0, 1, 3'd4, 32'h0,         4'b0000, 32'h0);
    bus(1, 0, 3'd4, 32'h0,         4'h0,    32'hAABB_CCDD);
    bus(0, 1, 3'd4, 32'h9912_3456, 4'b1000, 32'h0);
    bus(1, 0, 3'd4, 32'h0,         4'h0,    32'h99BB_CCDD);
    // Writes to read-only and unmapped words have no effect.
    bus(0, 1, 3'd0, 32'hDEAD_BEEF, 4'hF,    32'h0);
    bus(0, 1, 3'd6, 32'hDEAD_BEEF, 4'hF,    32'h0);
    bus(0, 1, 3'd3, 32'hDEAD_BEEF, 4'hF,    32'h0);
    bus(1, 0, 3'd0, 32'h0,         4'h0,    SYSID);
    bus(1, 0, 3'd6, 32'h0,         4'h0,    32'h0);
    bus(1, 0, 3'd4, 32'h0,         4'h0,    32'h99BB_CCDD);
    repeat (4) @(negedge clock);

    // The uptime snapshot stays clear until the first low-word read.
    // After that, the low-to-high read pair is tear-free across the 32-bit carry.
    bus(1, 0, 3'd3, 32'h0, 4'h0, 32'h0);
    u_l1.uptime = 64'h0000_0001_FFFF_FFFF;
    u_l2.uptime = 64'h0000_0001_FFFF_FFFF;
    u_l3.uptime = 64'h0000_0001_FFFF_FFFF;
    bus(1, 0, 3'd2, 32'h0, 4'h0, 32'hFFFF_FFFF);
    bus(1, 0, 3'd3, 32'h0, 4'h0, 32'h0000_0001);
    bus(1, 0, 3'd2, 32'h0, 4'h0, 32'h0000_0001);
    bus(1, 0, 3'd3, 32'h0, 4'h0, 32'h0000_0002);
    repeat (4) @(negedge clock);

    // Reset right after a read: only the latency-1 instance delivers its beat
    // before the reset edge.
    read = 1'b1; address = 3'd4;
    e.data = 32'h99BB_CCDD; e.due = cyc + 1; e.addr = 3'd4;
    sb[0].push_back(e);
    @(negedge clock);
    read = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    bus(1, 0, 3'd4, 32'h0, 4'h0, SCR_INIT);
    bus(1, 0, 3'd3, 32'h0, 4'h0, 32'h0);
    bus(1, 0, 3'd0, 32'h0, 4'h0, SYSID);

    // Drain with a bounded wait.
    budget = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    vectors++;
    if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
      miscompares++;
      $display("FAIL drain: %0d beats outstanding, required 0",
               sb[0].size() + sb[1].size() + sb[2].size());
    end
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
